// File: rtl/ripple_borrow_subtractor_pkg.sv
// Shared constants, state encoding and parameter checks for the multi-cycle
// ripple-borrow subtractor.
package ripple_borrow_subtractor_pkg;

    localparam int unsigned WIDTH_DEF = 64;
    localparam int unsigned SLICE_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic bit width_ok(input int unsigned width, input int unsigned slice);
        return (slice != 0) && ((width % slice) == 0);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ripple_borrow_subtractor_if.sv
// Request/result bundle of the subtractor; zero/neg/ovf exist only when
// SUB_FLAGS_EN is defined.
interface ripple_borrow_subtractor_if
    import ripple_borrow_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bi;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bo;
`ifdef SUB_FLAGS_EN
    logic             zero;
    logic             neg;
    logic             ovf;
`endif

    modport master (
        output start, a, b, bi,
        input  busy, done, d, bo
`ifdef SUB_FLAGS_EN
        , zero, neg, ovf
`endif
    );

    modport slave (
        input  start, a, b, bi,
        output busy, done, d, bo
`ifdef SUB_FLAGS_EN
        , zero, neg, ovf
`endif
    );

endinterface

// File: rtl/ripple_borrow_subtractor_slice.sv
// Combinational SLICE-bit digit subtractor: a - b - bin with borrow-out.
module slice_subtractor
    import ripple_borrow_subtractor_pkg::*;
#(
    parameter int unsigned SLICE = SLICE_DEF
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             bin_i,
    output logic [SLICE-1:0] diff_c_o,
    output logic             bout_c_o
);

    localparam int unsigned RW = SLICE + 1;

    logic [RW-1:0] res;

    // The extra top bit goes to 1 exactly when the digit result is negative.
    assign res = {1'b0, a_i} - {1'b0, b_i} - RW'(bin_i);
    assign {bout_c_o, diff_c_o} = res;

endmodule

// File: rtl/ripple_borrow_subtractor.sv
// Multi-cycle d = a - b - bi, one SLICE digit per clock with a registered
// borrow between digits. Optional result flags under SUB_FLAGS_EN.
module ripple_borrow_subtractor
    import ripple_borrow_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned SLICE = SLICE_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    ripple_borrow_subtractor_if.slave  bus
);

    localparam int unsigned N  = WIDTH / SLICE;
    localparam int unsigned KW = cnt_width(N);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] RUN  = ST_RUN;
    localparam logic [1:0] DONE = ST_DONE;

    if (!width_ok(WIDTH, SLICE)) begin : g_bad_width
        $error("ripple_borrow_subtractor: WIDTH must be a nonzero multiple of SLICE");
    end

    logic [1:0]       state_q,  state_d;
    logic [KW-1:0]    k_q,      k_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic             a_msb_q,  a_msb_d;
    logic             b_msb_q,  b_msb_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] d_q,      d_d;
    logic             bo_q,     bo_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
`ifdef SUB_FLAGS_EN
    logic             zero_q,   zero_d;
    logic             neg_q,    neg_d;
    logic             ovf_q,    ovf_d;
`endif

    logic [SLICE-1:0] slice_diff;
    logic             slice_bout;

    // Operands shift right so the current digit always sits in the low slice.
    slice_subtractor #(.SLICE(SLICE)) u_slice (
        .a_i      (a_q[SLICE-1:0]),
        .b_i      (b_q[SLICE-1:0]),
        .bin_i    (borrow_q),
        .diff_c_o (slice_diff),
        .bout_c_o (slice_bout)
    );

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        a_d      = a_q;
        b_d      = b_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        borrow_d = borrow_q;
        d_d      = d_q;
        bo_d     = bo_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
`ifdef SUB_FLAGS_EN
        zero_d   = zero_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    a_msb_d  = bus.a[WIDTH-1];
                    b_msb_d  = bus.b[WIDTH-1];
                    borrow_d = bus.bi;
                    k_d      = '0;
                    state_d  = RUN;
                    busy_d   = 1'b1;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                a_d      = a_q >> SLICE;
                b_d      = b_q >> SLICE;
                // Digits enter at the top; after N steps digit 0 lands at bit 0.
                d_d      = WIDTH'({slice_diff, d_q} >> SLICE);
                borrow_d = slice_bout;
                k_d      = k_q + KW'(1);
                if (k_q == KW'(N - 1)) begin
                    bo_d    = slice_bout;
                    state_d = DONE;
                    done_d  = 1'b1;
`ifdef SUB_FLAGS_EN
                    zero_d  = (d_d == '0);
                    neg_d   = d_d[WIDTH-1];
                    ovf_d   = (a_msb_q != b_msb_q) && (d_d[WIDTH-1] != a_msb_q);
`endif
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            borrow_q <= 1'b0;
            d_q      <= '0;
            bo_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SUB_FLAGS_EN
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            a_q      <= a_d;
            b_q      <= b_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            borrow_q <= borrow_d;
            d_q      <= d_d;
            bo_q     <= bo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SUB_FLAGS_EN
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.d    = d_q;
    assign bus.bo   = bo_q;
`ifdef SUB_FLAGS_EN
    assign bus.zero = zero_q;
    assign bus.neg  = neg_q;
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_ripple_borrow_subtractor.sv
// Directed bench for ripple_borrow_subtractor (64-bit, 8-bit slices); flag
// checks are compiled in when SUB_FLAGS_EN is defined.
module tb_ripple_borrow_subtractor;

    localparam int unsigned W = 64;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bi;
        logic [W-1:0] d;
        logic         bo;
        logic         zero;
        logic         neg;
        logic         ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    ripple_borrow_subtractor_if #(.WIDTH(W)) bus ();

    ripple_borrow_subtractor #(.WIDTH(W), .SLICE(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one request and return at the sample point of its done cycle.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic biv,
                          output int lat, output logic seen);
        @(negedge clk);
        bus.start = 1'b1; bus.a = av; bus.b = bv; bus.bi = biv;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.a = ~av; bus.b = ~bv; bus.bi = ~biv;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 50) begin
            @(posedge clk); #1;
            lat++;
            if (bus.done) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 64'(0), 64'(1));
    endtask

    vec_t vecs[8];

    initial begin
        int   lat;
        logic seen;
        int   dones;
        int   done_at;
        logic [W-1:0] dval;

        vecs[0] = '{64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{64'h100, 64'd1, 1'b0, 64'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{64'h1234, 64'h1234, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{64'h1234, 64'h1234, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b1};

        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bi = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_d",    bus.d,         64'(0));
        check("rst_bo",   64'(bus.bo),   64'(0));
`ifdef SUB_FLAGS_EN
        check("rst_flags", 64'({bus.zero, bus.neg, bus.ovf}), 64'(0));
`endif
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bi, lat, seen);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(8));
            check($sformatf("v%0d_d", i),  bus.d,          vecs[i].d);
            check($sformatf("v%0d_bo", i), 64'(bus.bo),    64'(vecs[i].bo));
            check($sformatf("v%0d_busy_at_done", i), 64'(bus.busy), 64'(0));
`ifdef SUB_FLAGS_EN
            check($sformatf("v%0d_zero", i), 64'(bus.zero), 64'(vecs[i].zero));
            check($sformatf("v%0d_neg", i),  64'(bus.neg),  64'(vecs[i].neg));
            check($sformatf("v%0d_ovf", i),  64'(bus.ovf),  64'(vecs[i].ovf));
`endif
            @(posedge clk); #1;
            check($sformatf("v%0d_done_pulse", i), 64'(bus.done), 64'(0));
            check($sformatf("v%0d_d_held", i),     bus.d,         vecs[i].d);
        end

        // start during RUN must be ignored
        @(negedge clk);
        bus.start = 1'b1; bus.a = 64'd7; bus.b = 64'd2; bus.bi = 1'b0;
        @(posedge clk); #1; bus.start = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.a = 64'd99; bus.b = 64'd1; bus.bi = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bi = 1'b0;
        dones = 0; done_at = -1; dval = '0;
        for (int e = 4; e < 24; e++) begin
            @(posedge clk); #1;
            if (bus.done) begin dones++; done_at = e; dval = bus.d; end
        end
        check("ign_done_count", 64'(dones),   64'(1));
        check("ign_done_edge",  64'(done_at), 64'(8));
        check("ign_d",          dval,         64'd5);

        // synchronous reset mid-RUN aborts the operation
        @(negedge clk);
        bus.start = 1'b1; bus.a = 64'hFFFF; bus.b = 64'd1; bus.bi = 1'b0;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_done", 64'(bus.done), 64'(0));
        check("abort_d",    bus.d,         64'(0));
        check("abort_bo",   64'(bus.bo),   64'(0));
`ifdef SUB_FLAGS_EN
        check("abort_flags", 64'({bus.zero, bus.neg, bus.ovf}), 64'(0));
`endif
        @(negedge clk); rst = 1'b0;
        dones = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        check("abort_no_done", 64'(dones), 64'(0));
        run_op(64'd7, 64'd2, 1'b0, lat, seen);
        check("post_abort_latency", 64'(lat),    64'(8));
        check("post_abort_d",       bus.d,       64'd5);
        check("post_abort_bo",      64'(bus.bo), 64'(0));
        @(posedge clk); #1;

        // start held high: back-to-back results every 9 cycles
        dones = 0;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.a = 64'(100 + 3 * c);
            bus.b = 64'(c);
            bus.bi = 1'b0;
            @(posedge clk); #1;
            check($sformatf("b2b_done_c%0d", c), 64'(bus.done), 64'((c % 9) == 8));
            check($sformatf("b2b_busy_c%0d", c), 64'(bus.busy), 64'((c % 9) != 8));
            if ((c % 9) == 8) begin
                check($sformatf("b2b_d_c%0d", c), bus.d, 64'(100 + 18 * (c / 9)));
                check($sformatf("b2b_bo_c%0d", c), 64'(bus.bo), 64'(0));
            end
            if (bus.done) dones++;
        end
        @(negedge clk); bus.start = 1'b0;
        check("b2b_done_count", 64'(dones), 64'(4));
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
